rshift_arb_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the team's 4-bit right shift register (Q <= {SDR, Q[3:1]}, synchronous active-low clear). It grants one requester at a time using round-robin. It clears the register, then serially feeds the granted word LSB-first on SDR so that the register holds the word after W shifts. It flags the single cycle in which the register's Q equals the word.

---
 rtl/rshift_arb_ctrl.sv | 141 ++++++++++++++
 tb/tb_rshift_arb_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rshift_arb_ctrl.sv
// Round-robin arbiter/sequencer that loads a granted word into a downstream W-bit right shift register.
// Latency: gnt one cycle after the grant edge, done W+2 cycles after it; one transfer every W+3 cycles.
// Backpressure: requests are sampled only in IDLE; requesters hold req until their gnt pulse.
module rshift_arb_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clrb,
    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sr_clrb,
    output logic         sdr,
    output logic         shen,
    output logic         done,
    output logic         owner,
    output logic         busy,
    output logic [7:0]   xfer_cnt
);

    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  word_q, word_d;
    logic          owner_q, owner_d;
    // prio_q names the requester that wins when both request at once
    logic          prio_q, prio_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          win;

    logic gnt0_q, gnt0_d;
    logic gnt1_q, gnt1_d;
    logic sr_clrb_q, sr_clrb_d;
    logic sdr_q, sdr_d;
    logic shen_q, shen_d;
    logic done_q, done_d;
    logic busy_q, busy_d;

    // Sequencer next state: arbitrate and capture in IDLE, then clear, shift W bits, report
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    win     = (req0 & req1) ? prio_q : req1;
                    owner_d = win;
                    word_d  = win ? data1 : data0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + 8'd1;
                prio_d  = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight from a flop
    always_comb begin
        gnt0_d    = (state_d == S_CLEAR) && !owner_d;
        gnt1_d    = (state_d == S_CLEAR) &&  owner_d;
        sr_clrb_d = (state_d != S_CLEAR);
        shen_d    = (state_d == S_SHIFT);
        sdr_d     = (state_d == S_SHIFT) ? word_d[k_d] : 1'b0;
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers; reset holds the downstream register cleared
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            word_q    <= '0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            cnt_q     <= 8'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            sr_clrb_q <= 1'b0;
            sdr_q     <= 1'b0;
            shen_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            word_q    <= word_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            sr_clrb_q <= sr_clrb_d;
            sdr_q     <= sdr_d;
            shen_q    <= shen_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign sr_clrb  = sr_clrb_q;
    assign sdr      = sdr_q;
    assign shen     = shen_q;
    assign done     = done_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_rshift_arb_ctrl.sv
// Bench for rshift_arb_ctrl: vector table of transfers plus abort and counter-wrap sequences.
// A model of the downstream shift register is checked against a queue of expected words at done.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_rshift_arb_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         clrb;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, sr_clrb, sdr, shen, done, owner, busy;
    logic [7:0]   xfer_cnt;

    typedef struct {
        logic         r0;
        logic         r1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         eown;
        logic [W-1:0] eword;
        logic         scr;   // flip input data right after the grant
        logic         spc;   // previous done expected exactly W+3 cycles earlier
    } vec_t;

    vec_t         vecs[11];
    logic [W-1:0] sb[$];
    logic [W-1:0] mq;
    logic [7:0]   exp_cnt;
    int           nvec = 0;
    int           nfail = 0;
    int           cyc = 0;
    int           last_done = -100;

    rshift_arb_ctrl #(.W(W)) dut (
        .clk(clk), .clrb(clrb),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sr_clrb(sr_clrb), .sdr(sdr), .shen(shen),
        .done(done), .owner(owner), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register: Q <= {SDR, Q[W-1:1]}, synchronous active-low clear
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sr_clrb) mq <= '0;
        else          mq <= {sdr, mq[W-1:1]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one transfer at the current falling edge and follow it to the next IDLE cycle
    task automatic apply(input vec_t v);
        bit           got;
        int           bitn;
        int           gcyc;
        logic [W-1:0] w;
        req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
        sb.push_back(v.eword);
        got = 0;
        for (int t = 0; t < 3 && !got; t++) begin
            @(negedge clk);
            if (gnt0 | gnt1) got = 1;
        end
        chk("grant_seen", got, 1);
        if (!got) begin
            sb.delete();
            return;
        end
        gcyc = cyc;
        chk("gnt0", gnt0, !v.eown);
        chk("gnt1", gnt1, v.eown);
        chk("owner_at_gnt", owner, v.eown);
        chk("sr_clrb_at_gnt", sr_clrb, 0);
        chk("busy_at_gnt", busy, 1);
        if (v.scr) begin
            data0 = ~data0;
            data1 = ~data1;
        end
        bitn = 0;
        got = 0;
        for (int t = 0; t < W + 3 && !got; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
            end else if (shen) begin
                if (bitn < W) chk("sdr_bit", sdr, v.eword[bitn]);
                bitn++;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("done_latency", cyc - gcyc, W + 1);
            chk("shift_count", bitn, W);
            chk("shen_at_done", shen, 0);
            chk("busy_at_done", busy, 1);
            chk("owner_at_done", owner, v.eown);
            if (v.spc) chk("done_spacing", cyc - last_done, W + 3);
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 0, 1);
            end else begin
                w = sb.pop_front();
                chk("done_q_word", mq, w);
            end
        end else begin
            sb.delete();
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("xfer_cnt", xfer_cnt, exp_cnt);
        chk("busy_idle", busy, 0);
        chk("sr_clrb_idle", sr_clrb, 1);
    endtask

    initial begin
        bit   got;
        vec_t v;

        vecs[0]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 4'hA, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 4'h5, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 4'hA, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 4'h5, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'hB, 4'h5, 1'b0, 4'hB, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'hB, 4'h3, 1'b1, 4'h3, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'hB, 4'h3, 1'b1, 4'h3, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'hB, 4'h3, 1'b1, 4'h3, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'hF, 4'h3, 1'b0, 4'hF, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 4'h5, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'hC, 4'h5, 1'b0, 4'hC, 1'b0, 1'b1};

        clrb = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_sr_clrb", sr_clrb, 0);
        chk("rst_sdr", sdr, 0);
        chk("rst_shen", shen, 0);
        chk("rst_done", done, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        clrb = 1'b1;
        @(negedge clk);
        chk("idle_sr_clrb", sr_clrb, 1);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 11; i++) apply(vecs[i]);

        // Abort in the middle of shifting (k=2); the last owner was 0, so priority sits with 1
        req0 = 1'b1; req1 = 1'b0; data0 = 4'h9;
        got = 0;
        for (int t = 0; t < 3 && !got; t++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        chk("abort_grant_seen", got, 1);
        repeat (3) @(negedge clk);
        chk("abort_shen_before", shen, 1);
        chk("abort_busy_before", busy, 1);
        #2;
        clrb = 1'b0; req0 = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_shen", shen, 0);
        chk("abort_sdr", sdr, 0);
        chk("abort_sr_clrb", sr_clrb, 0);
        chk("abort_owner", owner, 0);
        chk("abort_xfer_cnt", xfer_cnt, 0);
        exp_cnt = 8'd0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_no_gnt", gnt0 | gnt1, 0);
        end
        clrb = 1'b1;
        v = '{1'b1, 1'b1, 4'h6, 4'h9, 1'b0, 4'h6, 1'b0, 1'b0};
        apply(v);

        // Counter wrap: fresh reset, then 256 transfers of 1
        clrb = 1'b0; req0 = 1'b0; req1 = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        clrb = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v.r0 = 1'b1; v.r1 = 1'b0; v.d0 = 4'h1; v.d1 = 4'h0;
            v.eown = 1'b0; v.eword = 4'h1; v.scr = 1'b0; v.spc = (i > 0);
            apply(v);
            if (i == 254) chk("xfer_cnt_255", xfer_cnt, 255);
            if (i == 255) chk("xfer_cnt_wrap", xfer_cnt, 0);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
